ntt_ctrl: RTL and testbench
===========================

# ntt_ctrl

Sequencing controller for the NTT datapath. It drives one 256-coefficient in-place forward NTT or inverse NTT (7 layers, 128 butterflies per layer) through `butterfly_core`. It generates read addresses for the coefficient RAM, zeta ROM addresses, the butterfly mode, and write-back addresses delayed to match the RAM-plus-butterfly pipeline. It sits directly upstream of `butterfly_core`: RAM read data and ROM data go straight to `in_1`, `in_2` and `coef`, and `out_1`/`out_2` return to the RAM write port.

## Interface
**Parameters**
- `PIPE_LAT`, default 6: cycles from read issue to write-back. This is the 1-cycle RAM/ROM read plus the 5-cycle butterfly latency. Legal range is 2–15.

**Ports**
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: request a transform. Sampled only in IDLE.
- `inv` in 1: transform direction, sampled with `start`. 0 = forward NTT, 1 = inverse NTT.
- `busy` out 1: high from the first issue cycle through the last write cycle.
- `done` out 1: one-cycle pulse after the last write.
- `rd_en` out 1: RAM read strobe (one butterfly issued).
- `rd_addr_a` out 8: address of the upper operand `a[j]`.
- `rd_addr_b` out 8: address of the lower operand `a[j+len]`.
- `zeta_addr` out 7: zeta ROM index. Valid when `rd_en` is high.
- `bf_mode` out 2: `butterfly_core` mode. 0 = NTT, 1 = INTT. Constant while `busy` is high.
- `wr_en` out 1: RAM write strobe, equal to `rd_en` delayed by `PIPE_LAT`.
- `wr_addr_a` out 8: `rd_addr_a` delayed by `PIPE_LAT`.
- `wr_addr_b` out 8: `rd_addr_b` delayed by `PIPE_LAT`.

## Operation
**States**
- IDLE:
  - If `start` is high, latch `inv`, clear the layer counter `L` and the butterfly counter `b`, and go to RUN.
- RUN:
  - One butterfly is issued per cycle, with `rd_en` = 1.
  - `b` counts 0..127. At `b` = 127, go to DRAIN.
- DRAIN:
  - `rd_en` = 0 for `PIPE_LAT` cycles, so that every write of layer `L` completes before layer `L+1` reads.
  - Then, if `L` = 6, go to DONE. Otherwise increment `L`, clear `b`, and go to RUN.
- DONE:
  - `done` = 1 and `busy` = 0 for one cycle, then go to IDLE.

**Address arithmetic.** Let `s` = log2(len).
- Forward: len = 128 >> L.
- Inverse: len = 2 << L.
- Group index g = b >> s.
- Offset j = b & (len−1).
- `rd_addr_a` = (g << (s+1)) + j.
- `rd_addr_b` = `rd_addr_a` + len.
- All arithmetic is 8-bit unsigned. No overflow is possible by construction.

**Zeta index**
- Forward: `zeta_addr` = 2^L + g. This runs 1..127, ascending across the whole transform.
- Inverse: `zeta_addr` = 2^(7−L) − 1 − g. This runs 127..1, descending across the whole transform.

**Boundary rules**
- `start` is ignored while `busy` is high or in DONE.
- The write-back pipeline is a `PIPE_LAT`-deep shift register of {valid, addr_a, addr_b}. It is not stalled. In DRAIN it keeps shifting and only zeros enter.
- `rst` asserted mid-transform returns the block to IDLE and clears every pipeline valid bit. No `wr_en` is asserted after reset. RAM contents are left partially transformed.
- The final multiply by n⁻¹/Montgomery scaling for the inverse transform is not performed here.

## Timing
- **Reset values:** all outputs are 0, and the state is IDLE.
- **Start:** `start` sampled high at edge T0 makes layer `L` issue on cycles T0 + L·(128+`PIPE_LAT`) + 1 through … + 128.
- **Write-back:** `wr_en` for each butterfly occurs exactly `PIPE_LAT` cycles after its `rd_en`.
- **Completion (default `PIPE_LAT` = 6):**
  - The last write is at T0+938.
  - `done` pulses at T0+939.
  - `busy` is high for T0+1..T0+938.
- **Back-to-back:** a new `start` is accepted in IDLE on the cycle after `done`.

## Configuration
- Macro `NTT_CTRL_INTT_EN`.
- **Defined:** inverse transform supported as specified.
- **Undefined:**
  - The `inv` port remains but is ignored.
  - `bf_mode` is always 0.
  - Only the forward `len` and `zeta_addr` formulas are built.
  - Timing is identical.

## Test plan
- **Forward, first and last issue:** `start` with `inv` = 0.
  - First `rd_en`: `rd_addr_a`/`rd_addr_b`/`zeta_addr` = 0/128/1.
  - Last issue of layer 0: 127/255/1.
  - First issue of layer 6: 0/2/64.
  - Last issue of layer 6: 253/255/127.
  - `done` at T0+939.
- **Inverse:** `start` with `inv` = 1.
  - First `rd_en`: 0/2/127.
  - Layer 0 `b` = 2: 4/6/126.
  - Layer 6 issue: 0/128/1.
  - `bf_mode` = 1 throughout `busy`.
- **Pipeline alignment:** record every `rd_en`. `wr_en`/`wr_addr_a`/`wr_addr_b` must match each one 6 cycles later. 896 writes in total, and no layer-`L+1` read precedes the final layer-`L` write.
- **Start ignored:** `start` pulsed at T0+300 during a transform has no effect, and `done` still occurs at T0+939.
- **Reset mid-run:** `rst` asserted at T0+500 clears all outputs immediately. No `wr_en` occurs afterwards. A new `start` gives correct first addresses.
- **Config off:** with `NTT_CTRL_INTT_EN` undefined, `inv` = 1 still produces the forward sequence 0/128/1 and `bf_mode` = 0.

Source files
------------

// File: rtl/ntt_ctrl_if.sv
// ntt_ctrl_if - signal bundle between the NTT sequencing controller and the
// surrounding datapath (coefficient RAM, zeta ROM, butterfly_core).
//
// Signals:
//   start, inv            : transform request and direction (into controller)
//   busy, done            : transform status (from controller)
//   rd_en, rd_addr_a/b    : coefficient RAM read strobe and operand addresses
//   zeta_addr             : zeta ROM index, valid with rd_en
//   bf_mode               : butterfly_core mode (0 = NTT, 1 = INTT)
//   wr_en, wr_addr_a/b    : RAM write-back strobe and addresses
//
// Modports:
//   master : the controller side (drives everything except start/inv)
//   slave  : the requester/datapath side
interface ntt_ctrl_if;
  logic       start;
  logic       inv;
  logic       busy;
  logic       done;
  logic       rd_en;
  logic [7:0] rd_addr_a;
  logic [7:0] rd_addr_b;
  logic [6:0] zeta_addr;
  logic [1:0] bf_mode;
  logic       wr_en;
  logic [7:0] wr_addr_a;
  logic [7:0] wr_addr_b;

  modport master (
    input  start, inv,
    output busy, done, rd_en, rd_addr_a, rd_addr_b, zeta_addr, bf_mode,
           wr_en, wr_addr_a, wr_addr_b
  );

  modport slave (
    output start, inv,
    input  busy, done, rd_en, rd_addr_a, rd_addr_b, zeta_addr, bf_mode,
           wr_en, wr_addr_a, wr_addr_b
  );
endinterface

// File: rtl/ntt_ctrl.sv
// ntt_ctrl - sequencing controller for one 256-coefficient in-place NTT/INTT
// (7 layers x 128 butterflies) driven through butterfly_core.
//
// Issues one butterfly per cycle (RAM read addresses, zeta index, mode), then
// idles for PIPE_LAT cycles after each layer so all write-backs of the layer
// land before the next layer reads. Write addresses are the read addresses
// delayed by PIPE_LAT through an unstalled shift register.
//
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset (state to IDLE, write pipe emptied)
//   bus  : ntt_ctrl_if.master (start/inv in; busy/done/rd_*/zeta_addr/
//          bf_mode/wr_* out)
//
// Parameters:
//   PIPE_LAT : read-issue to write-back latency, 2..15 (default 6)
//
// Configuration macro:
//   NTT_CTRL_INTT_EN : when defined, inv selects the inverse transform; when
//                      undefined, inv is ignored and only the forward address
//                      and zeta sequence is built (timing unchanged).
module ntt_ctrl #(
  parameter int PIPE_LAT = 6
) (
  input  logic       clk,
  input  logic       rst,
  ntt_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam logic [3:0] DRAIN_LAST = 4'(PIPE_LAT - 1);

  state_t     state_q, state_d;
  logic [2:0] layer_q, layer_d;
  logic [6:0] bfly_q,  bfly_d;
  logic [3:0] drain_q, drain_d;
  logic       issue;
  logic       mode_inv;

`ifdef NTT_CTRL_INTT_EN
  logic inv_q, inv_d;
  assign mode_inv = inv_q;
`else
  logic unused_inv;
  assign unused_inv = bus.inv;
  assign mode_inv   = 1'b0;
`endif

  // Control state: FSM, layer/butterfly/drain counters, latched direction
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      layer_q <= '0;
      bfly_q  <= '0;
      drain_q <= '0;
`ifdef NTT_CTRL_INTT_EN
      inv_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      layer_q <= layer_d;
      bfly_q  <= bfly_d;
      drain_q <= drain_d;
`ifdef NTT_CTRL_INTT_EN
      inv_q   <= inv_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    layer_d = layer_q;
    bfly_d  = bfly_q;
    drain_d = drain_q;
`ifdef NTT_CTRL_INTT_EN
    inv_d   = inv_q;
`endif
    issue   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_RUN;
          layer_d = '0;
          bfly_d  = '0;
`ifdef NTT_CTRL_INTT_EN
          inv_d   = bus.inv;
`endif
        end
      end
      S_RUN: begin
        issue  = 1'b1;
        bfly_d = bfly_q + 7'd1;
        if (bfly_q == 7'd127) begin
          state_d = S_DRAIN;
          drain_d = '0;
        end
      end
      S_DRAIN: begin
        drain_d = drain_q + 4'd1;
        if (drain_q == DRAIN_LAST) begin
          if (layer_q == 3'd6) begin
            state_d = S_DONE;
          end else begin
            layer_d = layer_q + 3'd1;
            bfly_d  = '0;
            state_d = S_RUN;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Address and zeta generation from (layer, butterfly).
  // shift_s = log2(len); off_mask = len-1 kept 7 bits wide since len-1 <= 127.
  logic [2:0] shift_s;
  logic [6:0] grp;
  logic [6:0] off_mask;
  logic [6:0] off;
  logic [7:0] len;
  logic [7:0] addr_a;
  logic [7:0] addr_b;
  logic [6:0] zeta;

  always_comb begin
`ifdef NTT_CTRL_INTT_EN
    shift_s = mode_inv ? (layer_q + 3'd1) : (3'd7 - layer_q);
`else
    shift_s = 3'd7 - layer_q;
`endif
    grp      = bfly_q >> shift_s;
    off_mask = 7'h7f >> (3'd7 - shift_s);
    off      = bfly_q & off_mask;
    len      = {1'b0, off_mask} + 8'd1;
    addr_a   = ({1'b0, grp} << ({1'b0, shift_s} + 4'd1)) + {1'b0, off};
    addr_b   = addr_a + len;
`ifdef NTT_CTRL_INTT_EN
    // 7'h7f >> L equals 2^(7-L) - 1
    zeta = mode_inv ? ((7'h7f >> layer_q) - grp) : ((7'd1 << layer_q) + grp);
`else
    zeta = (7'd1 << layer_q) + grp;
`endif
  end

  // Write-back delay line: valid is control (reset), addresses are data
  logic       wb_vld_q [PIPE_LAT];
  logic       wb_vld_d [PIPE_LAT];
  logic [7:0] wb_a_q   [PIPE_LAT];
  logic [7:0] wb_a_d   [PIPE_LAT];
  logic [7:0] wb_b_q   [PIPE_LAT];
  logic [7:0] wb_b_d   [PIPE_LAT];

  always_comb begin
    // Address taps are gated with issue so only zeros enter while draining
    wb_vld_d[0] = issue;
    wb_a_d[0]   = issue ? addr_a : 8'd0;
    wb_b_d[0]   = issue ? addr_b : 8'd0;
    for (int i = 1; i < PIPE_LAT; i++) begin
      wb_vld_d[i] = wb_vld_q[i-1];
      wb_a_d[i]   = wb_a_q[i-1];
      wb_b_d[i]   = wb_b_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < PIPE_LAT; i++) begin
        wb_vld_q[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < PIPE_LAT; i++) begin
        wb_vld_q[i] <= wb_vld_d[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < PIPE_LAT; i++) begin
      wb_a_q[i] <= wb_a_d[i];
      wb_b_q[i] <= wb_b_d[i];
    end
  end

  // Outputs: read-side fields forced to zero when no butterfly is issued
  logic busy_w;
  logic wr_en_w;

  assign busy_w        = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign wr_en_w       = wb_vld_q[PIPE_LAT-1];

  assign bus.busy      = busy_w;
  assign bus.done      = (state_q == S_DONE);
  assign bus.rd_en     = issue;
  assign bus.rd_addr_a = issue ? addr_a : 8'd0;
  assign bus.rd_addr_b = issue ? addr_b : 8'd0;
  assign bus.zeta_addr = issue ? zeta : 7'd0;
  assign bus.bf_mode   = busy_w ? {1'b0, mode_inv} : 2'd0;
  assign bus.wr_en     = wr_en_w;
  assign bus.wr_addr_a = wr_en_w ? wb_a_q[PIPE_LAT-1] : 8'd0;
  assign bus.wr_addr_b = wr_en_w ? wb_b_q[PIPE_LAT-1] : 8'd0;

endmodule

// File: tb/tb_ntt_ctrl.sv
// tb_ntt_ctrl - scoreboard bench for ntt_ctrl.
// The stimulus process requests transforms with random direction and pushes
// the expected read, write and done events (from a textbook NTT loop nest)
// into queues; a monitor samples the DUT on every falling edge and compares.
module tb_ntt_ctrl;

  localparam int LAT      = 6;
  localparam int PERIOD   = 128 + LAT;
  localparam int DONE_OFS = 7 * PERIOD;  // bench cycles from first issue to done

  typedef struct {
    int cyc;
    int a;
    int b;
    int z;
  } item_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ntt_ctrl_if bus ();

  ntt_ctrl #(.PIPE_LAT(LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  int    cyc = 0;
  int    checks = 0;
  int    failures = 0;
  item_t rdq[$];
  item_t wrq[$];
  int    doneq[$];
  int    tb_t0 = -100000;  // first issue cycle of the current transform
  int    tb_inv = 0;       // effective direction of the current transform

  always @(posedge clk) cyc++;

  function automatic void chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0d required=%0d", name, cyc, act, exp);
    end
  endfunction

  function automatic int eff_inv(input int i);
`ifdef NTT_CTRL_INTT_EN
    return i;
`else
    return 0;
`endif
  endfunction

  // Reference: Kyber-style loop nest; zeta index steps once per group.
  function automatic void push_transform(input int t0, input int inv);
    item_t it;
    int k, n, len;
    k = inv ? 127 : 1;
    for (int l = 0; l < 7; l++) begin
      len = inv ? (2 << l) : (128 >> l);
      n = 0;
      for (int st = 0; st < 256; st += 2 * len) begin
        for (int j = st; j < st + len; j++) begin
          it.cyc = t0 + l * PERIOD + n;
          it.a   = j;
          it.b   = j + len;
          it.z   = k;
          rdq.push_back(it);
          it.cyc = it.cyc + LAT;
          wrq.push_back(it);
          n++;
        end
        k = inv ? k - 1 : k + 1;
      end
    end
    doneq.push_back(t0 + DONE_OFS);
    tb_t0  = t0;
    tb_inv = inv;
  endfunction

  // Monitor
  always @(negedge clk) begin
    if (!rst) begin
      item_t it;
      int exp_busy, exp_done;
      exp_busy = (cyc >= tb_t0 && cyc <= tb_t0 + DONE_OFS - 1) ? 1 : 0;
      chk("busy", int'(bus.busy), exp_busy);
      chk("bf_mode", int'(bus.bf_mode), exp_busy ? tb_inv : 0);
      exp_done = (doneq.size() > 0 && doneq[0] == cyc) ? 1 : 0;
      if (exp_done == 1) void'(doneq.pop_front());
      chk("done", int'(bus.done), exp_done);
      if (rdq.size() > 0 && rdq[0].cyc < cyc) begin
        chk("rd_missing", cyc, rdq[0].cyc);
        void'(rdq.pop_front());
      end
      if (wrq.size() > 0 && wrq[0].cyc < cyc) begin
        chk("wr_missing", cyc, wrq[0].cyc);
        void'(wrq.pop_front());
      end
      if (bus.rd_en) begin
        if (rdq.size() == 0) chk("rd_unexpected", 1, 0);
        else begin
          it = rdq.pop_front();
          chk("rd_cycle", cyc, it.cyc);
          chk("rd_addr_a", int'(bus.rd_addr_a), it.a);
          chk("rd_addr_b", int'(bus.rd_addr_b), it.b);
          chk("zeta_addr", int'(bus.zeta_addr), it.z);
        end
      end
      if (bus.wr_en) begin
        if (wrq.size() == 0) chk("wr_unexpected", 1, 0);
        else begin
          it = wrq.pop_front();
          chk("wr_cycle", cyc, it.cyc);
          chk("wr_addr_a", int'(bus.wr_addr_a), it.a);
          chk("wr_addr_b", int'(bus.wr_addr_b), it.b);
        end
      end
    end
  end

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_rd_en"}, int'(bus.rd_en), 0);
    chk({tag, "_wr_en"}, int'(bus.wr_en), 0);
    chk({tag, "_busy"}, int'(bus.busy), 0);
    chk({tag, "_done"}, int'(bus.done), 0);
    chk({tag, "_rd_addr_a"}, int'(bus.rd_addr_a), 0);
    chk({tag, "_rd_addr_b"}, int'(bus.rd_addr_b), 0);
    chk({tag, "_zeta_addr"}, int'(bus.zeta_addr), 0);
    chk({tag, "_bf_mode"}, int'(bus.bf_mode), 0);
    chk({tag, "_wr_addr_a"}, int'(bus.wr_addr_a), 0);
    chk({tag, "_wr_addr_b"}, int'(bus.wr_addr_b), 0);
  endtask

  // Called at a falling edge with the DUT in IDLE; start is sampled next edge.
  task automatic begin_xform(input int inv);
    bus.start = 1'b1;
    bus.inv   = inv[0];
    push_transform(cyc + 1, eff_inv(inv));
    @(negedge clk);
    bus.start = 1'b0;
    bus.inv   = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!bus.done && n < 1200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.done) chk("done_timeout", 0, 1);
  endtask

  initial begin
    int r;
    bus.start = 1'b0;
    bus.inv   = 1'b0;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);

    // Forward transform with a stray start mid-run
    begin_xform(0);
    wait_until(tb_t0 + 298);
    bus.start = 1'b1;
    bus.inv   = 1'($urandom_range(0, 1));
    @(negedge clk);
    bus.start = 1'b0;
    wait_done();

    // Back-to-back inverse; start already high while done is shown
    bus.start = 1'b1;
    bus.inv   = 1'b1;
    @(negedge clk);
    begin_xform(1);
    wait_done();

    // Random directions, back-to-back
    repeat (2) begin
      r = int'($urandom_range(0, 1));
      bus.start = 1'b1;
      bus.inv   = r[0];
      @(negedge clk);
      begin_xform(r);
      wait_done();
    end

    // Reset in the middle of a transform
    @(negedge clk);
    begin_xform(0);
    wait_until(tb_t0 + 498);
    @(posedge clk);
    #2 rst = 1'b1;
    rdq.delete();
    wrq.delete();
    doneq.delete();
    tb_t0 = -100000;
    #1 check_outputs_zero("midrst");
    @(posedge clk);
    #2 rst = 1'b0;
    repeat (20) @(negedge clk);

    // Fresh transform after reset
    begin_xform(int'($urandom_range(0, 1)));
    wait_done();

    repeat (5) @(negedge clk);
    chk("rdq_empty", rdq.size(), 0);
    chk("wrq_empty", wrq.size(), 0);
    chk("doneq_empty", doneq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
